// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini SRC control unit: opcodes, FSM steps,
// instruction classes and the strobe bundle driven into the datapath.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BRX  = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU3, C_UNARY, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_BRX,
        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } iclass_t;

    typedef struct packed {
        logic       gra;
        logic       grb;
        logic       grc;
        logic       rin;
        logic       rout;
        logic       ba_out;
        logic       pc_in;
        logic       ir_in;
        logic       mar_in;
        logic       mdr_in;
        logic       y_in;
        logic       z_in;
        logic       hi_in;
        logic       lo_in;
        logic       con_in;
        logic       outport_in;
        logic       pc_out;
        logic       mdr_out;
        logic       y_out;
        logic       zhigh_out;
        logic       zlow_out;
        logic       hi_out;
        logic       lo_out;
        logic       inport_out;
        logic       c_out;
        logic       inc_pc;
        logic       read;
        logic       write;
        logic [4:0] alu_op;
    } ctrl_t;

    function automatic iclass_t op_class(input logic [4:0] op);
        iclass_t c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:     c = C_ALU3;
            OP_NEG, OP_NOT:                      c = C_UNARY;
            OP_ADDI, OP_ANDI, OP_ORI:            c = C_IMM;
            OP_LDI:                              c = C_LDI;
            OP_LD:                               c = C_LD;
            OP_ST:                               c = C_ST;
            OP_MUL, OP_DIV:                      c = C_MULDIV;
            OP_BRX:                              c = C_BRX;
            OP_JR:                               c = C_JR;
            OP_IN:                               c = C_IN;
            OP_OUT:                              c = C_OUT;
            OP_MFHI:                             c = C_MFHI;
            OP_MFLO:                             c = C_MFLO;
            OP_HALT:                             c = C_HALT;
            default:                             c = C_NOP;
        endcase
        return c;
    endfunction

    // Final execute step of each class; the step after it is the next fetch.
    function automatic state_t last_step(input iclass_t c);
        state_t s;
        case (c)
            C_UNARY:                    s = S_T4;
            C_ALU3, C_IMM, C_LDI:       s = S_T5;
            C_MULDIV, C_BRX:            s = S_T6;
            C_LD, C_ST:                 s = S_T7;
            default:                    s = S_T3;
        endcase
        return s;
    endfunction

    function automatic logic is_wait_step(input state_t s, input iclass_t c);
        return ((c == C_LD) && (s == S_T6)) || ((c == C_ST) && (s == S_T7));
    endfunction

    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        logic [4:0] a;
        case (op)
            OP_ANDI: a = OP_AND;
            OP_ORI:  a = OP_OR;
            default: a = OP_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational strobe decode: maps the current step and instruction class
// to the full set of datapath control signals.
module cu_decode
    import cpu_pkg::*;
(
    input  state_t     state_i,
    input  iclass_t    cls_i,
    input  logic [4:0] op_i,
    input  logic       con_ff_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_T0: begin
                ctrl_o.pc_out = 1'b1;
                ctrl_o.mar_in = 1'b1;
                ctrl_o.inc_pc = 1'b1;
                ctrl_o.z_in   = 1'b1;
            end
            S_T1: begin
                ctrl_o.zlow_out = 1'b1;
                ctrl_o.pc_in    = 1'b1;
                ctrl_o.read     = 1'b1;
                ctrl_o.mdr_in   = 1'b1;
            end
            S_T2: begin
                ctrl_o.mdr_out = 1'b1;
                ctrl_o.ir_in   = 1'b1;
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (cls_i)
                    C_ALU3: begin
                        case (state_i)
                            S_T3: begin ctrl_o.grb = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.y_in = 1'b1; end
                            S_T4: begin
                                ctrl_o.grc = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.z_in = 1'b1;
                                ctrl_o.alu_op = op_i;
                            end
                            S_T5: begin ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_UNARY: begin
                        case (state_i)
                            S_T3: begin
                                ctrl_o.grb = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.z_in = 1'b1;
                                ctrl_o.alu_op = op_i;
                            end
                            S_T4: begin ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    // Immediate, ldi, ld and st all form rb/0 + C in Z first.
                    C_IMM, C_LDI, C_LD, C_ST: begin
                        case (state_i)
                            S_T3: begin
                                ctrl_o.grb  = 1'b1;
                                ctrl_o.y_in = 1'b1;
                                if (cls_i == C_IMM) ctrl_o.rout = 1'b1;
                                else                ctrl_o.ba_out = 1'b1;
                            end
                            S_T4: begin
                                ctrl_o.c_out  = 1'b1;
                                ctrl_o.z_in   = 1'b1;
                                ctrl_o.alu_op = (cls_i == C_IMM) ? imm_alu_op(op_i) : OP_ADD;
                            end
                            S_T5: begin
                                ctrl_o.zlow_out = 1'b1;
                                if (cls_i == C_LD || cls_i == C_ST) begin
                                    ctrl_o.mar_in = 1'b1;
                                end else begin
                                    ctrl_o.gra = 1'b1;
                                    ctrl_o.rin = 1'b1;
                                end
                            end
                            S_T6: begin
                                if (cls_i == C_LD) begin
                                    ctrl_o.read   = 1'b1;
                                    ctrl_o.mdr_in = 1'b1;
                                end else if (cls_i == C_ST) begin
                                    ctrl_o.gra    = 1'b1;
                                    ctrl_o.rout   = 1'b1;
                                    ctrl_o.mdr_in = 1'b1;
                                end
                            end
                            S_T7: begin
                                if (cls_i == C_LD) begin
                                    ctrl_o.mdr_out = 1'b1;
                                    ctrl_o.gra     = 1'b1;
                                    ctrl_o.rin     = 1'b1;
                                end else if (cls_i == C_ST) begin
                                    ctrl_o.write = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    C_MULDIV: begin
                        case (state_i)
                            S_T3: begin ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.y_in = 1'b1; end
                            S_T4: begin
                                ctrl_o.grb = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.z_in = 1'b1;
                                ctrl_o.alu_op = op_i;
                            end
                            S_T5: begin ctrl_o.zlow_out = 1'b1; ctrl_o.lo_in = 1'b1; end
                            S_T6: begin ctrl_o.zhigh_out = 1'b1; ctrl_o.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_BRX: begin
                        case (state_i)
                            S_T3: begin ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.con_in = 1'b1; end
                            S_T4: begin ctrl_o.pc_out = 1'b1; ctrl_o.y_in = 1'b1; end
                            S_T5: begin
                                ctrl_o.c_out = 1'b1; ctrl_o.z_in = 1'b1;
                                ctrl_o.alu_op = OP_ADD;
                            end
                            S_T6: begin ctrl_o.zlow_out = 1'b1; ctrl_o.pc_in = con_ff_i; end
                            default: ;
                        endcase
                    end
                    C_JR:   if (state_i == S_T3) begin ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.pc_in = 1'b1; end
                    C_IN:   if (state_i == S_T3) begin ctrl_o.inport_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1; end
                    C_OUT:  if (state_i == S_T3) begin ctrl_o.gra = 1'b1; ctrl_o.rout = 1'b1; ctrl_o.outport_in = 1'b1; end
                    C_MFHI: if (state_i == S_T3) begin ctrl_o.hi_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1; end
                    C_MFLO: if (state_i == S_T3) begin ctrl_o.lo_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.rin = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit for the Mini SRC datapath: fetch/execute
// step sequencing, memory wait states and run/halt ownership.
module control_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [ADDR_W-1:0] ir,
    input  logic              con_ff,
    input  logic              mem_ready,
    input  logic              stop,
    output logic              run,
    output logic              gra,
    output logic              grb,
    output logic              grc,
    output logic              rin,
    output logic              rout,
    output logic              ba_out,
    output logic              pc_in,
    output logic              ir_in,
    output logic              mar_in,
    output logic              mdr_in,
    output logic              y_in,
    output logic              z_in,
    output logic              hi_in,
    output logic              lo_in,
    output logic              con_in,
    output logic              outport_in,
    output logic              pc_out,
    output logic              mdr_out,
    output logic              y_out,
    output logic              zhigh_out,
    output logic              zlow_out,
    output logic              hi_out,
    output logic              lo_out,
    output logic              inport_out,
    output logic              c_out,
    output logic              inc_pc,
    output logic              read,
    output logic              write,
    output logic [4:0]        alu_op
);

    state_t     state_q, state_d;
    logic [4:0] op;
    iclass_t    cls;
    ctrl_t      dec_ctrl, ctrl;
    logic       unused_ir;

    // Register fields are consumed by the datapath's select/encode logic.
    assign op        = ir[ADDR_W-1 -: 5];
    assign unused_ir = ^ir[ADDR_W-6:0];
    assign cls       = op_class(op);

    always_ff @(posedge clock) begin
        if (clear) state_q <= S_T0;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_HALT: state_d = S_HALT;
            default: begin
                if (cls == C_HALT)
                    state_d = S_HALT;
                else if (is_wait_step(state_q, cls) && !mem_ready)
                    state_d = state_q;
                else if (state_q == last_step(cls))
                    state_d = stop ? S_HALT : S_T0;
                else
                    state_d = state_t'(state_q + 4'd1);
            end
        endcase
    end

    cu_decode u_decode (
        .state_i  (state_q),
        .cls_i    (cls),
        .op_i     (op),
        .con_ff_i (con_ff),
        .ctrl_o   (dec_ctrl)
    );

    // Outputs are forced quiet while clear is held, whatever the old state.
    assign ctrl = clear ? '0 : dec_ctrl;
    assign run  = !clear && (state_q != S_HALT);

    assign gra        = ctrl.gra;
    assign grb        = ctrl.grb;
    assign grc        = ctrl.grc;
    assign rin        = ctrl.rin;
    assign rout       = ctrl.rout;
    assign ba_out     = ctrl.ba_out;
    assign pc_in      = ctrl.pc_in;
    assign ir_in      = ctrl.ir_in;
    assign mar_in     = ctrl.mar_in;
    assign mdr_in     = ctrl.mdr_in;
    assign y_in       = ctrl.y_in;
    assign z_in       = ctrl.z_in;
    assign hi_in      = ctrl.hi_in;
    assign lo_in      = ctrl.lo_in;
    assign con_in     = ctrl.con_in;
    assign outport_in = ctrl.outport_in;
    assign pc_out     = ctrl.pc_out;
    assign mdr_out    = ctrl.mdr_out;
    assign y_out      = ctrl.y_out;
    assign zhigh_out  = ctrl.zhigh_out;
    assign zlow_out   = ctrl.zlow_out;
    assign hi_out     = ctrl.hi_out;
    assign lo_out     = ctrl.lo_out;
    assign inport_out = ctrl.inport_out;
    assign c_out      = ctrl.c_out;
    assign inc_pc     = ctrl.inc_pc;
    assign read       = ctrl.read;
    assign write      = ctrl.write;
    assign alu_op     = ctrl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed and random instructions checked step by
// step against a per-opcode strobe table built from the instruction set.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear, con_ff, mem_ready, stop;
    logic [31:0] ir;
    logic        run, gra, grb, grc, rin, rout, ba_out;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, con_in, outport_in;
    logic        pc_out, mdr_out, y_out, zhigh_out, zlow_out, hi_out, lo_out, inport_out, c_out;
    logic        inc_pc, read, write;
    logic [4:0]  alu_op;

    always #5 clock = ~clock;

    control_unit #(.ADDR_W(32)) dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
        .stop(stop), .run(run), .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
        .ba_out(ba_out), .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in), .con_in(con_in),
        .outport_in(outport_in), .pc_out(pc_out), .mdr_out(mdr_out), .y_out(y_out),
        .zhigh_out(zhigh_out), .zlow_out(zlow_out), .hi_out(hi_out), .lo_out(lo_out),
        .inport_out(inport_out), .c_out(c_out), .inc_pc(inc_pc), .read(read),
        .write(write), .alu_op(alu_op)
    );

    localparam logic [33:0] GRA        = 34'd1 << 0;
    localparam logic [33:0] GRB        = 34'd1 << 1;
    localparam logic [33:0] GRC        = 34'd1 << 2;
    localparam logic [33:0] RIN        = 34'd1 << 3;
    localparam logic [33:0] ROUT       = 34'd1 << 4;
    localparam logic [33:0] BA_OUT     = 34'd1 << 5;
    localparam logic [33:0] PC_IN      = 34'd1 << 6;
    localparam logic [33:0] IR_IN      = 34'd1 << 7;
    localparam logic [33:0] MAR_IN     = 34'd1 << 8;
    localparam logic [33:0] MDR_IN     = 34'd1 << 9;
    localparam logic [33:0] Y_IN       = 34'd1 << 10;
    localparam logic [33:0] Z_IN       = 34'd1 << 11;
    localparam logic [33:0] HI_IN      = 34'd1 << 12;
    localparam logic [33:0] LO_IN      = 34'd1 << 13;
    localparam logic [33:0] CON_IN     = 34'd1 << 14;
    localparam logic [33:0] OUTPORT_IN = 34'd1 << 15;
    localparam logic [33:0] PC_OUT     = 34'd1 << 16;
    localparam logic [33:0] MDR_OUT    = 34'd1 << 17;
    localparam logic [33:0] Y_OUT      = 34'd1 << 18;
    localparam logic [33:0] ZHIGH_OUT  = 34'd1 << 19;
    localparam logic [33:0] ZLOW_OUT   = 34'd1 << 20;
    localparam logic [33:0] HI_OUT     = 34'd1 << 21;
    localparam logic [33:0] LO_OUT     = 34'd1 << 22;
    localparam logic [33:0] INPORT_OUT = 34'd1 << 23;
    localparam logic [33:0] C_OUT      = 34'd1 << 24;
    localparam logic [33:0] INC_PC     = 34'd1 << 25;
    localparam logic [33:0] READ       = 34'd1 << 26;
    localparam logic [33:0] WRITE      = 34'd1 << 27;
    localparam logic [33:0] RUN        = 34'd1 << 28;
    localparam logic [33:0] BUS_M      = ROUT | BA_OUT | PC_OUT | MDR_OUT | Y_OUT | ZHIGH_OUT |
                                         ZLOW_OUT | HI_OUT | LO_OUT | INPORT_OUT | C_OUT;

    logic [33:0] obs;
    assign obs = {alu_op, run, write, read, inc_pc, c_out, inport_out, lo_out, hi_out,
                  zlow_out, zhigh_out, y_out, mdr_out, pc_out, outport_in, con_in, lo_in,
                  hi_in, z_in, y_in, mdr_in, mar_in, ir_in, pc_in, ba_out, rout, rin,
                  grc, grb, gra};

    int total = 0;
    int bad   = 0;

    function automatic logic [33:0] alu(input logic [4:0] op);
        return {op, 29'd0};
    endfunction

    task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: list of execute-step strobe sets for one instruction.
    logic [33:0] exp_q[$];
    int          wait_idx;
    bit          is_halt;

    task automatic push(input logic [33:0] s);
        exp_q.push_back(s | RUN);
    endtask

    task automatic build_model(input logic [4:0] op, input logic con);
        exp_q    = {};
        wait_idx = -1;
        is_halt  = 1'b0;
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                push(GRB | ROUT | Y_IN); push(GRC | ROUT | Z_IN | alu(op)); push(ZLOW_OUT | GRA | RIN);
            end
            5'd17, 5'd18: begin
                push(GRB | ROUT | Z_IN | alu(op)); push(ZLOW_OUT | GRA | RIN);
            end
            5'd12, 5'd13, 5'd14: begin
                push(GRB | ROUT | Y_IN);
                push(C_OUT | Z_IN | alu(op == 5'd12 ? 5'd3 : (op == 5'd13 ? 5'd5 : 5'd6)));
                push(ZLOW_OUT | GRA | RIN);
            end
            5'd1: begin
                push(GRB | BA_OUT | Y_IN); push(C_OUT | Z_IN | alu(5'd3)); push(ZLOW_OUT | GRA | RIN);
            end
            5'd0, 5'd2: begin
                push(GRB | BA_OUT | Y_IN); push(C_OUT | Z_IN | alu(5'd3)); push(ZLOW_OUT | MAR_IN);
                if (op == 5'd0) begin
                    push(READ | MDR_IN); push(MDR_OUT | GRA | RIN); wait_idx = 3;
                end else begin
                    push(GRA | ROUT | MDR_IN); push(WRITE); wait_idx = 4;
                end
            end
            5'd15, 5'd16: begin
                push(GRA | ROUT | Y_IN); push(GRB | ROUT | Z_IN | alu(op));
                push(ZLOW_OUT | LO_IN); push(ZHIGH_OUT | HI_IN);
            end
            5'd19: begin
                push(GRA | ROUT | CON_IN); push(PC_OUT | Y_IN); push(C_OUT | Z_IN | alu(5'd3));
                push(ZLOW_OUT | (con ? PC_IN : 34'd0));
            end
            5'd20: push(GRA | ROUT | PC_IN);
            5'd22: push(INPORT_OUT | GRA | RIN);
            5'd23: push(GRA | ROUT | OUTPORT_IN);
            5'd24: push(HI_OUT | GRA | RIN);
            5'd25: push(LO_OUT | GRA | RIN);
            5'd27: begin push(34'd0); is_halt = 1'b1; end
            default: push(34'd0);
        endcase
    endtask

    // Inputs are already set; sample mid-cycle, then advance past the edge.
    task automatic step(input string tag, input logic [33:0] exp);
        @(negedge clock);
        check_eq(tag, obs, exp);
        check_eq({tag, "_bus"}, 34'($countones(obs & BUS_M) <= 1), 34'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear(input int n);
        clear = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            stop      = 1'($urandom_range(0, 1));
            step("clear", 34'd0);
        end
        clear = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ir_w, input int t1w, input int mw,
                             input int stop_at, input int abort_at, input logic con,
                             output bit halted);
        int n;
        build_model(ir_w[31:27], con);
        n      = exp_q.size();
        ir     = ir_w;
        con_ff = con;
        halted = 1'b0;
        $display("instr ir=%h op=%0d t1w=%0d mw=%0d stop_at=%0d abort_at=%0d con=%0b",
                 ir_w, ir_w[31:27], t1w, mw, stop_at, abort_at, con);
        stop = (stop_at >= 0) ? 1'b0 : 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        step("T0", PC_OUT | MAR_IN | INC_PC | Z_IN | RUN);
        for (int i = 0; i < t1w; i++) begin
            mem_ready = 1'b0;
            step("T1_wait", ZLOW_OUT | PC_IN | READ | MDR_IN | RUN);
        end
        mem_ready = 1'b1;
        step("T1", ZLOW_OUT | PC_IN | READ | MDR_IN | RUN);
        mem_ready = 1'($urandom_range(0, 1));
        step("T2", MDR_OUT | IR_IN | RUN);
        for (int s = 0; s < n; s++) begin
            string tag;
            tag = $sformatf("op%0d_T%0d", ir_w[31:27], s + 3);
            if (stop_at >= 0) stop = (s >= stop_at);
            else              stop = (s == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (s == abort_at) begin
                clear = 1'b1;
                stop  = 1'b0;
                step({tag, "_abort"}, 34'd0);
                clear = 1'b0;
                return;
            end
            if (s == wait_idx) begin
                for (int w = 0; w < mw; w++) begin
                    mem_ready = 1'b0;
                    step({tag, "_wait"}, exp_q[s]);
                end
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            step(tag, exp_q[s]);
        end
        halted = is_halt || (stop_at >= 0 && stop_at < n);
        if (halted) begin
            for (int i = 0; i < 2; i++) begin
                mem_ready = 1'($urandom_range(0, 1));
                stop      = 1'($urandom_range(0, 1));
                step("HALT", 34'd0);
            end
        end
    endtask

    initial begin
        bit h;
        clear = 1'b1; ir = 32'd0; con_ff = 1'b0; mem_ready = 1'b0; stop = 1'b0;
        do_clear(2);

        run_instr(32'h18918000, 0, 0, -1, -1, 1'b0, h);           // add r1,r2,r3
        run_instr({5'd0,  27'($urandom)}, 0, 3, -1, -1, 1'b0, h);   // ld, 3 wait cycles
        run_instr({5'd19, 27'($urandom)}, 1, 0, -1, -1, 1'b0, h);   // brx not taken
        run_instr({5'd19, 27'($urandom)}, 0, 0, -1, -1, 1'b1, h);   // brx taken
        run_instr({5'd15, 27'($urandom)}, 0, 0, -1, -1, 1'b0, h);   // mul
        run_instr({5'd2,  27'($urandom)}, 2, 2, -1, -1, 1'b0, h);   // st with waits
        run_instr(32'h18918000, 0, 0, 1, -1, 1'b0, h);             // stop raised in T4
        check_eq("stop_halted", 34'(h), 34'd1);
        do_clear(1);
        run_instr({5'd27, 27'($urandom)}, 0, 0, -1, -1, 1'b0, h);   // halt opcode
        do_clear(1);
        run_instr({5'd0,  27'($urandom)}, 0, 2, -1, 3, 1'b0, h);    // clear aborts ld in T6
        run_instr({5'd26, 27'($urandom)}, 0, 0, -1, -1, 1'b0, h);   // nop

        for (int k = 0; k < 300; k++) begin
            int sa, ab;
            sa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
            ab = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr({5'($urandom_range(0, 31)), 27'($urandom)},
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      sa, ab, 1'($urandom_range(0, 1)), h);
            if (h) do_clear(int'($urandom_range(1, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
